// File: rtl/hc595_rx_pkg.sv
// Shared constants for the 74HC595 display link receiver.
// Provides default frame geometry and the link idle levels. The idle levels
// double as synchronizer reset values, so no edge is seen on reset release.
package hc595_rx_pkg;

  localparam int unsigned HC_FRAME_BITS  = 14;
  localparam int unsigned HC_SEL_W       = 6;
  localparam int unsigned HC_SEG_W       = 8;
  localparam int unsigned HC_SYNC_STAGES = 2;

  // Width of the per-frame bit counter (saturates at all-ones)
  localparam int unsigned BIT_CNT_W = 4;

  // Idle link levels
  localparam logic IDLE_STCP = 1'b0;
  localparam logic IDLE_SHCP = 1'b0;
  localparam logic IDLE_DS   = 1'b0;
  localparam logic IDLE_OE   = 1'b1;

  // Saturating increment for the bit counter
  function automatic logic [BIT_CNT_W-1:0] sat_inc_bits(input logic [BIT_CNT_W-1:0] v);
    sat_inc_bits = (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hc595_rx_sync_edge.sv
// Multi-stage synchronizer with a registered rising-edge pulse.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   din        asynchronous input
//   level      synchronized level (STAGES cycles of delay)
//   level_dly  level delayed one more cycle; aligned with rise
//   rise       one-cycle pulse, registered, on a synchronized 0->1 transition
module hc595_rx_sync_edge #(
  parameter int unsigned STAGES = 2,
  parameter logic        IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic level_dly,
  output logic rise
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= {STAGES{IDLE}};
      level_dly <= IDLE;
      rise      <= 1'b0;
    end else begin
      sync      <= {sync[STAGES-2:0], din};
      level_dly <= sync[STAGES-1];
      // level_dly is the previous synchronized level, so this is the edge
      rise      <= sync[STAGES-1] & ~level_dly;
    end
  end

  assign level = sync[STAGES-1];

endmodule

// File: rtl/hc595_rx.sv
// Receive end of the 74HC595 display link.
// Recovers the serial frame sent on ds/shcp/stcp/oe and presents the latched
// digit-select / segment values along with frame status and counters.
// Ports:
//   sys_clk, sys_rst   system clock, synchronous active-high reset
//   stcp, shcp, ds, oe asynchronous link inputs (oe active-low)
//   sel, seg           latched digit select / segment pattern
//   disp_en            synchronized ~oe
//   frame_vld          pulse on every latch
//   frame_err          pulse with frame_vld when the bit count was wrong
//   frame_cnt          latches since reset (wraps)
//   err_cnt            bad frames since reset (saturates)
module hc595_rx
  import hc595_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = HC_SYNC_STAGES,
  parameter int unsigned FRAME_BITS  = HC_FRAME_BITS,
  parameter int unsigned SEL_W       = HC_SEL_W,
  parameter int unsigned SEG_W       = HC_SEG_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             stcp,
  input  logic             shcp,
  input  logic             ds,
  input  logic             oe,
  output logic [SEL_W-1:0] sel,
  output logic [SEG_W-1:0] seg,
  output logic             disp_en,
  output logic             frame_vld,
  output logic             frame_err,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam logic [BIT_CNT_W-1:0] FRAME_CNT = BIT_CNT_W'(FRAME_BITS);

  logic shcp_rise, stcp_rise, ds_d, oe_lvl;
  logic shcp_lvl, shcp_dly, stcp_lvl, stcp_dly, ds_lvl, ds_rise, oe_dly, oe_rise;

  hc595_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(IDLE_SHCP)) u_sync_shcp (
    .clk(sys_clk), .rst(sys_rst), .din(shcp),
    .level(shcp_lvl), .level_dly(shcp_dly), .rise(shcp_rise)
  );

  hc595_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(IDLE_STCP)) u_sync_stcp (
    .clk(sys_clk), .rst(sys_rst), .din(stcp),
    .level(stcp_lvl), .level_dly(stcp_dly), .rise(stcp_rise)
  );

  // ds goes through the same depth plus the edge register, so ds_d is the
  // value present at the synchronized shcp rise
  hc595_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(IDLE_DS)) u_sync_ds (
    .clk(sys_clk), .rst(sys_rst), .din(ds),
    .level(ds_lvl), .level_dly(ds_d), .rise(ds_rise)
  );

  // oe uses the undelayed level so disp_en lands SYNC_STAGES+1 cycles out
  hc595_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(IDLE_OE)) u_sync_oe (
    .clk(sys_clk), .rst(sys_rst), .din(oe),
    .level(oe_lvl), .level_dly(oe_dly), .rise(oe_rise)
  );

  logic unused_sync;
  assign unused_sync = ^{shcp_lvl, shcp_dly, stcp_lvl, stcp_dly,
                         ds_lvl, ds_rise, oe_dly, oe_rise};

  logic [FRAME_BITS-1:0] shreg, sh_next;
  logic [BIT_CNT_W-1:0]  bit_cnt, cnt_next;
  logic [SEL_W-1:0]      sel_next;
  logic [SEG_W-1:0]      seg_next;
  logic                  bad_len;

  // Shift is resolved before the latch so a same-cycle shcp/stcp rise
  // latches the post-shift register and counts the final bit
  always_comb begin
    sh_next  = shreg;
    cnt_next = bit_cnt;
    if (shcp_rise) begin
      sh_next  = {shreg[FRAME_BITS-2:0], ds_d};
      cnt_next = sat_inc_bits(bit_cnt);
    end
    sel_next = '0;
    for (int unsigned i = 0; i < SEL_W; i++) begin
      sel_next[i] = sh_next[FRAME_BITS-1-i];
    end
    seg_next = sh_next[SEG_W-1:0];
    bad_len  = (cnt_next != FRAME_CNT);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      sel       <= '0;
      seg       <= '1;
      disp_en   <= 1'b0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      shreg     <= sh_next;
      disp_en   <= ~oe_lvl;
      frame_vld <= stcp_rise;
      frame_err <= stcp_rise & bad_len;
      if (stcp_rise) begin
        sel       <= sel_next;
        seg       <= seg_next;
        bit_cnt   <= '0;
        frame_cnt <= frame_cnt + 16'd1;
        if (bad_len && (err_cnt != '1)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end else begin
        bit_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_hc595_rx.sv
module tb_hc595_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stcp = 1'b0, shcp = 1'b0, ds = 1'b0, oe = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        disp_en, frame_vld, frame_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;
  int vld_seen = 0;
  logic last_err = 1'b0;

  always #5 clk = ~clk;

  hc595_rx #(.SYNC_STAGES(2), .FRAME_BITS(14), .SEL_W(6), .SEG_W(8)) dut (
    .sys_clk(clk), .sys_rst(rst), .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe),
    .sel(sel), .seg(seg), .disp_en(disp_en), .frame_vld(frame_vld),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  // Pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (frame_vld) begin
      vld_seen = vld_seen + 1;
      last_err = frame_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stcp = 1'b0; shcp = 1'b0; ds = 1'b0; oe = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    tick(2);
    shcp = 1'b1;
    tick(2);
    shcp = 1'b0;
    tick(2);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    logic [15:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) shift_bit(t[i]);
  endtask

  task automatic latch();
    stcp = 1'b1;
    tick(2);
    stcp = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    int v0;
    stcp = 1'b0; shcp = 1'b0; ds = 1'b0; oe = 1'b1;
    rst = 1'b1;
    tick(3);
    total++; if (sel !== 6'b0) begin bad++; $display("FAIL rst_sel got=%b exp=%b", sel, 6'b0); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL rst_seg got=%h exp=%h", seg, 8'hFF); end
    total++; if ({disp_en, frame_vld, frame_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {disp_en, frame_vld, frame_err}); end
    total++; if (frame_cnt !== 16'd0 || err_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnts got=%h/%h exp=0/0", frame_cnt, err_cnt); end
    v0 = vld_seen;
    rst = 1'b0;
    tick(6);
    total++; if (vld_seen - v0 !== 0) begin bad++; $display("FAIL rst_no_false_latch got=%0d exp=0", vld_seen - v0); end
  endtask

  // 14'b10_1010_0110_0101 MSB first -> sel=6'b010101, seg=8'h65; also latency
  task automatic test_direct();
    int v0;
    send_bits(16'h2A65, 14);
    v0 = vld_seen;
    stcp = 1'b1;
    tick(3);
    total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", frame_vld); end
    tick(1);
    total++; if (frame_vld !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL lat_pulse got=%b%b exp=10", frame_vld, frame_err); end
    total++; if (sel !== 6'b010101) begin bad++; $display("FAIL direct_sel got=%b exp=%b", sel, 6'b010101); end
    total++; if (seg !== 8'h65) begin bad++; $display("FAIL direct_seg got=%h exp=%h", seg, 8'h65); end
    tick(1);
    total++; if (frame_vld !== 1'b0) begin bad++; $display("FAIL lat_one_cycle got=%b exp=0", frame_vld); end
    stcp = 1'b0;
    tick(4);
    total++; if (frame_cnt !== 16'd1 || vld_seen - v0 !== 1) begin bad++; $display("FAIL direct_cnt got=%0d/%0d exp=1/1", frame_cnt, vld_seen - v0); end
  endtask

  // sel=6'b111110, seg=8'hC0 -> raw frame 14'h1FC0, sent twice
  task automatic test_loopback();
    int v0;
    for (int k = 0; k < 2; k++) begin
      v0 = vld_seen;
      send_bits(16'h1FC0, 14);
      latch();
      total++; if (sel !== 6'b111110 || seg !== 8'hC0) begin bad++; $display("FAIL loop_data%0d got=%b/%h exp=111110/c0", k, sel, seg); end
      total++; if (vld_seen - v0 !== 1 || last_err !== 1'b0) begin bad++; $display("FAIL loop_vld%0d got=%0d/%b exp=1/0", k, vld_seen - v0, last_err); end
    end
    total++; if (frame_cnt !== 16'd3 || err_cnt !== 8'd0) begin bad++; $display("FAIL loop_cnts got=%0d/%0d exp=3/0", frame_cnt, err_cnt); end
  endtask

  task automatic test_bad_len();
    do_reset();
    send_bits(16'h1FC0, 13);
    latch();
    total++; if (last_err !== 1'b1 || err_cnt !== 8'd1) begin bad++; $display("FAIL short_err got=%b/%0d exp=1/1", last_err, err_cnt); end
    // 15 bits: the leading 1 falls off, 14'h2A65 remains
    send_bits(16'h6A65, 15);
    latch();
    total++; if (sel !== 6'b010101 || seg !== 8'h65) begin bad++; $display("FAIL long_data got=%b/%h exp=010101/65", sel, seg); end
    total++; if (last_err !== 1'b1 || err_cnt !== 8'd2 || frame_cnt !== 16'd2) begin bad++; $display("FAIL long_err got=%b/%0d/%0d exp=1/2/2", last_err, err_cnt, frame_cnt); end
  endtask

  // Bit 14 shcp rise coincides with stcp rise
  task automatic test_simultaneous();
    do_reset();
    send_bits(16'h1532, 13);   // top 13 bits of 14'h2A65
    ds = 1'b1;
    tick(2);
    shcp = 1'b1; stcp = 1'b1;
    tick(2);
    shcp = 1'b0; stcp = 1'b0;
    tick(6);
    total++; if (sel !== 6'b010101 || seg !== 8'h65) begin bad++; $display("FAIL simul_data got=%b/%h exp=010101/65", sel, seg); end
    total++; if (last_err !== 1'b0 || err_cnt !== 8'd0 || frame_cnt !== 16'd1) begin bad++; $display("FAIL simul_err got=%b/%0d/%0d exp=0/0/1", last_err, err_cnt, frame_cnt); end
  endtask

  task automatic test_mid_reset();
    send_bits(16'h0055, 7);
    shcp = 1'b1;
    rst = 1'b1;
    tick(2);
    total++; if (sel !== 6'b0 || seg !== 8'hFF || frame_cnt !== 16'd0) begin bad++; $display("FAIL midrst_idle got=%b/%h/%0d exp=0/ff/0", sel, seg, frame_cnt); end
    shcp = 1'b0; ds = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    send_bits(16'h1FC0, 14);
    latch();
    total++; if (sel !== 6'b111110 || seg !== 8'hC0) begin bad++; $display("FAIL midrst_data got=%b/%h exp=111110/c0", sel, seg); end
    total++; if (last_err !== 1'b0 || frame_cnt !== 16'd1) begin bad++; $display("FAIL midrst_cnt got=%b/%0d exp=0/1", last_err, frame_cnt); end
  endtask

  task automatic test_oe();
    oe = 1'b0;
    tick(2);
    total++; if (disp_en !== 1'b0) begin bad++; $display("FAIL oe_fall_early got=%b exp=0", disp_en); end
    tick(1);
    total++; if (disp_en !== 1'b1) begin bad++; $display("FAIL oe_fall got=%b exp=1", disp_en); end
    oe = 1'b1;
    tick(2);
    total++; if (disp_en !== 1'b1) begin bad++; $display("FAIL oe_rise_early got=%b exp=1", disp_en); end
    tick(1);
    total++; if (disp_en !== 1'b0) begin bad++; $display("FAIL oe_rise got=%b exp=0", disp_en); end
    total++; if (sel !== 6'b111110 || seg !== 8'hC0) begin bad++; $display("FAIL oe_data got=%b/%h exp=111110/c0", sel, seg); end
  endtask

  // 256 zero-bit latches: every one is an error, err_cnt saturates
  task automatic test_back_to_back();
    int v0;
    do_reset();
    v0 = vld_seen;
    for (int k = 0; k < 256; k++) begin
      stcp = 1'b1;
      tick(2);
      stcp = 1'b0;
      tick(2);
    end
    tick(6);
    total++; if (frame_cnt !== 16'd256 || vld_seen - v0 !== 256) begin bad++; $display("FAIL b2b_cnt got=%0d/%0d exp=256/256", frame_cnt, vld_seen - v0); end
    total++; if (err_cnt !== 8'hFF || last_err !== 1'b1) begin bad++; $display("FAIL b2b_sat got=%h/%b exp=ff/1", err_cnt, last_err); end
    total++; if (sel !== 6'b0 || seg !== 8'h00) begin bad++; $display("FAIL b2b_data got=%b/%h exp=0/00", sel, seg); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_loopback();
    test_bad_len();
    test_simultaneous();
    test_mid_reset();
    test_oe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
